// File: rtl/ampel_pkg.sv
// Shared colour codes and phase type for the traffic light controller.
package ampel_pkg;

  localparam logic [1:0] GREEN     = 2'b00;
  localparam logic [1:0] YELLOW    = 2'b01;
  localparam logic [1:0] RED       = 2'b10;
  localparam logic [1:0] REDYELLOW = 2'b11;

  typedef enum logic [2:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_RED,
    PH_REDYELLOW,
    PH_NACHT
  } phase_t;

  // Night mode shows yellow; every other phase maps onto its own colour code.
  function automatic logic [1:0] phaseColour(input phase_t p);
    case (p)
      PH_GREEN:     phaseColour = GREEN;
      PH_YELLOW:    phaseColour = YELLOW;
      PH_RED:       phaseColour = RED;
      PH_REDYELLOW: phaseColour = REDYELLOW;
      default:      phaseColour = YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/ampel_knopf_sync.sv
// Pedestrian button path: two-flop synchroniser, rising-edge detect and request latch.
module ampel_knopf_sync (
  input  logic clk,
  input  logic rst,
  input  logic knopf,
  input  logic clear,
  input  logic block,
  output logic o_request,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_syncPrev;
  logic r_request;

  assign o_edge    = r_sync2 & ~r_syncPrev;
  assign o_request = r_request;

  // clear beats a simultaneous edge: the edge is consumed by the extension it triggers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_syncPrev <= 1'b0;
      r_request  <= 1'b0;
    end else begin
      r_sync1    <= knopf;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
      if (clear) begin
        r_request <= 1'b0;
      end else if (o_edge && !block) begin
        r_request <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ampel_steuerung.sv
// Traffic light phase controller with pedestrian-extended red.
// Optional night blink mode is enabled by defining AMPEL_NACHTMODUS_EN.
module ampel_steuerung
  import ampel_pkg::*;
#(
  parameter int T_GREEN     = 4,
  parameter int T_YELLOW    = 1,
  parameter int T_RED       = 2,
  parameter int T_REDYELLOW = 1,
  parameter int T_EXTEND    = 8,
  parameter int CNT_W       = 8
`ifdef AMPEL_NACHTMODUS_EN
  ,
  parameter int T_BLINK     = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       knopf,
`ifdef AMPEL_NACHTMODUS_EN
  input  logic       nacht,
  output logic       blink,
`endif
  output logic [1:0] ampelfarbe,
  output logic       fussgaenger_gruen,
  output logic       anforderung
);

  if (T_GREEN < 1 || T_YELLOW < 1 || T_RED < 1 || T_REDYELLOW < 1 || T_EXTEND < 1 ||
      T_GREEN > 2**CNT_W || T_YELLOW > 2**CNT_W || T_RED > 2**CNT_W ||
      T_REDYELLOW > 2**CNT_W || T_RED + T_EXTEND > 2**CNT_W) begin : g_paramCheck
    $error("ampel_steuerung: phase length out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] L_GREEN     = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] L_YELLOW    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_RED       = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] L_REDEXT    = CNT_W'(T_RED + T_EXTEND - 1);
  localparam logic [CNT_W-1:0] L_REDYELLOW = CNT_W'(T_REDYELLOW - 1);

  phase_t           r_phase;
  logic [CNT_W-1:0] r_timer;
  logic [1:0]       r_farbe;
  logic             r_fg;
  logic             w_request;
  logic             w_edge;
  logic             w_extend;
  logic             w_clear;
  logic             w_block;

`ifdef AMPEL_NACHTMODUS_EN
  if (T_BLINK < 1 || T_BLINK > 2**CNT_W) begin : g_blinkCheck
    $error("ampel_steuerung: T_BLINK out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] L_BLINK = CNT_W'(T_BLINK - 1);

  logic             r_blink;
  logic [CNT_W-1:0] r_blinkCnt;

  assign blink    = r_blink;
  assign w_extend = (r_phase == PH_YELLOW) && (r_timer == '0) && (w_request || w_edge) && !nacht;
  assign w_clear  = w_extend || nacht || (r_phase == PH_NACHT);
  assign w_block  = r_fg || (r_phase == PH_NACHT);
`else
  assign w_extend = (r_phase == PH_YELLOW) && (r_timer == '0) && (w_request || w_edge);
  assign w_clear  = w_extend;
  assign w_block  = r_fg;
`endif

  assign ampelfarbe        = r_farbe;
  assign fussgaenger_gruen = r_fg;
  assign anforderung       = w_request;

  ampel_knopf_sync u_knopfSync (
    .clk       (clk),
    .rst       (rst),
    .knopf     (knopf),
    .clear     (w_clear),
    .block     (w_block),
    .o_request (w_request),
    .o_edge    (w_edge)
  );

  // r_farbe is loaded together with r_phase so the colour never lags the phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_GREEN;
      r_timer <= L_GREEN;
      r_farbe <= GREEN;
      r_fg    <= 1'b0;
`ifdef AMPEL_NACHTMODUS_EN
      r_blink    <= 1'b0;
      r_blinkCnt <= '0;
    end else if (nacht) begin
      r_phase <= PH_NACHT;
      r_farbe <= phaseColour(PH_NACHT);
      r_fg    <= 1'b0;
      if (r_phase != PH_NACHT) begin
        r_blink    <= 1'b1;
        r_blinkCnt <= L_BLINK;
      end else if (r_blinkCnt == '0) begin
        r_blink    <= ~r_blink;
        r_blinkCnt <= L_BLINK;
      end else begin
        r_blinkCnt <= r_blinkCnt - 1'b1;
      end
    end else if (r_phase == PH_NACHT) begin
      r_phase <= PH_RED;
      r_timer <= L_RED;
      r_farbe <= RED;
      r_blink <= 1'b0;
`endif
    end else if (r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end else begin
      case (r_phase)
        PH_GREEN: begin
          r_phase <= PH_YELLOW;
          r_timer <= L_YELLOW;
          r_farbe <= YELLOW;
        end
        PH_YELLOW: begin
          r_phase <= PH_RED;
          r_timer <= w_extend ? L_REDEXT : L_RED;
          r_farbe <= RED;
          r_fg    <= w_extend;
        end
        PH_RED: begin
          r_phase <= PH_REDYELLOW;
          r_timer <= L_REDYELLOW;
          r_farbe <= REDYELLOW;
          r_fg    <= 1'b0;
        end
        default: begin
          r_phase <= PH_GREEN;
          r_timer <= L_GREEN;
          r_farbe <= GREEN;
          r_fg    <= 1'b0;
        end
      endcase
    end
  end

endmodule
